high_bit_assembler: RTL and testbench
=====================================

Name: high_bit_assembler

Overview:
Inverse of high_bit_search. It takes a stream of set-bit indices, MSB-first, one index per handshake beat, and rebuilds the original INPUT_WIDTH-bit word. When the beat marked last arrives, it presents the assembled word, the number of bits applied, and a sticky error flag. It sits downstream of the bit-index encoder path and reconstructs data words for the consumer.

Parameters:
INPUT_WIDTH, 16, width of the reconstructed word; any value >= 2.
INDEX_WIDTH, $clog2(INPUT_WIDTH), localparam; width of in_index.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  index beat valid
in_ready  output  1  block accepts beat this cycle
in_index  input  INDEX_WIDTH  bit position to set
in_null  input  1  beat carries no index (in_index ignored); used for all-zero words
in_last  input  1  final beat of word
out_valid  output  1  assembled word available
out_ready  input  1  consumer accepts word
out_data  output  INPUT_WIDTH  assembled word
out_count  output  INDEX_WIDTH+1  number of bits applied to out_data
out_err  output  1  word had a range or ordering violation

Behaviour:
- Reset (async, active-high): out_valid=0, out_data=0, out_count=0, out_err=0, in_ready=1. Internal accumulator, count, error, prev-index tracking and state are all cleared. Reset mid-word discards the partial word; no output is produced for it.
- States: ACCUM (collecting; first-beat flag set or clear) and HOLD (out_valid=1).
- in_ready = !out_valid || out_ready. Beats are accepted in HOLD only in the cycle the output is consumed.
- Beat accepted when in_valid && in_ready:
  - Non-null, in range, and either first beat of the word or in_index < prev_index: set bit in_index, count+1, prev_index <= in_index.
  - in_index >= INPUT_WIDTH (non-power-of-2 widths only): bit not set, count unchanged, err <= 1.
  - in_index >= prev_index on a non-first beat (duplicate or ascending order): bit not set, count unchanged, err <= 1.
  - in_null: no bit change and no count change. The error rules do not apply.
  - in_last: the next cycle shows out_valid=1, with out_data/out_count/out_err equal to the accumulated values including this beat. State goes to HOLD.
- Latency: the out_valid rising edge occurs one cycle after the last beat is accepted.
- HOLD: out_data/out_count/out_err remain stable while out_ready=0. When out_valid && out_ready, the word is consumed.
  - If no beat is accepted that cycle: out_valid <= 0, accumulator cleared, state goes to ACCUM with the first-beat flag set.
  - Simultaneous consume and accept: the accepted beat is the first beat of the new word and is applied to a cleared accumulator, so no throughput bubble occurs. If that beat also has in_last, out_valid stays 1 next cycle with the new word.
- out_data/out_count/out_err are registered outputs. Their values while out_valid=0 are don't-care, but they are held at the last word in practice.
- out_count saturation is impossible: at most INPUT_WIDTH bits can be legally applied, and INDEX_WIDTH+1 bits covers INPUT_WIDTH.
- in_index and in_null are ignored unless a beat is accepted.

Decomposition:
- Shared package: INDEX_WIDTH derivation function (clog2 wrapper) and the state encoding constants ST_ACCUM/ST_HOLD, also used by the encoder-side block.
- Single module; no sub-module needed. The optional one-hot index decoder can be a local function.

Test Plan:
- INPUT_WIDTH=16, beats 12,10,9,7,6,4,3,2,1(last), out_ready=1 -> out_data=16'h16DE, out_count=9, out_err=0, out_valid one cycle after the last beat.
- Single beat in_null=1, in_last=1 -> out_data=16'h0000, out_count=0, out_err=0. Then beat 15(last) -> 16'h8000, count 1.
- Word 14,12,10(last) with out_ready held 0 for 3 cycles -> in_ready=0 and outputs stable (16'h5400, count 3) throughout. On out_ready=1, the next word's first beat 7 is accepted in the same cycle. Following word 7,2(last) -> 16'h0084.
- Beats 5,5,9(last) -> out_data=16'h0020, out_count=1, out_err=1. The next word 3(last) -> 16'h0008, out_err=0 (error cleared per word).
- INPUT_WIDTH=12, beats 13,4(last) -> out_data=12'h010, out_count=1, out_err=1.
- Beats 11,8, then rst pulsed asynchronously mid-cycle -> outputs zero immediately. Next word 2(last) -> 16'h0004, count 1; no residue from the aborted word.

Source files
------------

// File: rtl/high_bit_assembler_pkg.sv
// rtl/high_bit_assembler_pkg.sv - shared index-width helper and state encoding for the bit-index path
package high_bit_assembler_pkg;

  // Shared with the encoder side so both ends agree on the state encoding.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } hba_state_e;

  // Width of a bit index for a word of the given width (at least one bit).
  function automatic int index_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/high_bit_assembler.sv
// rtl/high_bit_assembler.sv - rebuilds a word from an MSB-first stream of set-bit indices
module high_bit_assembler
  import high_bit_assembler_pkg::*;
#(
  parameter int  INPUT_WIDTH = 16,
  localparam int INDEX_WIDTH = index_width(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INDEX_WIDTH-1:0] in_index,
  input  logic                   in_null,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] out_data,
  output logic [INDEX_WIDTH:0]   out_count,
  output logic                   out_err
);

  localparam logic [INDEX_WIDTH:0] IDX_LIMIT = (INDEX_WIDTH + 1)'(INPUT_WIDTH);
  localparam logic [INDEX_WIDTH:0] CNT_ONE   = {{INDEX_WIDTH{1'b0}}, 1'b1};

  hba_state_e             state_q, state_d;
  logic                   first_q, first_d;
  logic [INPUT_WIDTH-1:0] acc_q, acc_d;
  logic [INDEX_WIDTH:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [INDEX_WIDTH-1:0] prev_q, prev_d;
  logic [INPUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [INDEX_WIDTH:0]   out_count_q, out_count_d;
  logic                   out_err_q, out_err_d;

  // Accumulator state as it would look after applying the current beat.
  logic [INPUT_WIDTH-1:0] beat_acc;
  logic [INDEX_WIDTH:0]   beat_cnt;
  logic                   beat_err;
  logic [INDEX_WIDTH-1:0] beat_prev;
  logic                   beat_first;

  logic accept;
  logic consume;
  logic out_of_range;
  logic out_of_order;

  function automatic logic [INPUT_WIDTH-1:0] one_hot(input logic [INDEX_WIDTH-1:0] idx);
    return {{(INPUT_WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign out_valid    = (state_q == ST_HOLD);
  assign in_ready     = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign consume      = out_valid && out_ready;
  // Zero-extend so the range test is meaningful for non-power-of-2 widths.
  assign out_of_range = ({1'b0, in_index} >= IDX_LIMIT);
  assign out_of_order = !first_q && (in_index >= prev_q);

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_err   = out_err_q;

  // Effect of one index beat; null beats and rejected indices leave the word untouched.
  always_comb begin
    beat_acc   = acc_q;
    beat_cnt   = cnt_q;
    beat_err   = err_q;
    beat_prev  = prev_q;
    beat_first = first_q;
    if (!in_null) begin
      if (out_of_range || out_of_order) begin
        beat_err = 1'b1;
      end else begin
        beat_acc   = acc_q | one_hot(in_index);
        beat_cnt   = cnt_q + CNT_ONE;
        beat_prev  = in_index;
        beat_first = 1'b0;
      end
    end
  end

  // Next state: the last beat publishes the word and clears the accumulator at once,
  // so a beat accepted in the consume cycle always starts a fresh word.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    prev_d      = prev_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;
    if (accept && in_last) begin
      out_data_d  = beat_acc;
      out_count_d = beat_cnt;
      out_err_d   = beat_err;
      acc_d       = '0;
      cnt_d       = '0;
      err_d       = 1'b0;
      prev_d      = '0;
      first_d     = 1'b1;
      state_d     = ST_HOLD;
    end else begin
      if (accept) begin
        acc_d   = beat_acc;
        cnt_d   = beat_cnt;
        err_d   = beat_err;
        prev_d  = beat_prev;
        first_d = beat_first;
      end
      if (consume) begin
        state_d = ST_ACCUM;
      end
    end
  end

  // State and output registers; reset drops any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      first_q     <= 1'b1;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      prev_q      <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      prev_q      <= prev_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_high_bit_assembler.sv
// tb/tb_high_bit_assembler.sv - randomized self-checking bench for high_bit_assembler (widths 16 and 12)
module tb_high_bit_assembler;

  typedef struct {
    int idx;
    bit nul;
  } beat_t;

  typedef struct {
    logic [15:0] d16;
    int          c16;
    bit          e16;
    logic [15:0] d12;
    int          c12;
    bit          e12;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_index;
  logic        in_null;
  logic        in_last;
  logic        out_ready;
  logic        in_ready, out_valid, out_err;
  logic [15:0] out_data;
  logic [4:0]  out_count;
  logic        in_ready12, out_valid12, out_err12;
  logic [11:0] out_data12;
  logic [4:0]  out_count12;

  int    checks = 0;
  int    errors = 0;
  bit    force_en = 1'b1;
  bit    force_val = 1'b1;
  int    last_wait;
  beat_t cur[$];
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  high_bit_assembler #(.INPUT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_index(in_index), .in_null(in_null), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_err(out_err)
  );

  high_bit_assembler #(.INPUT_WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
    .in_index(in_index), .in_null(in_null), .in_last(in_last),
    .out_valid(out_valid12), .out_ready(out_ready), .out_data(out_data12),
    .out_count(out_count12), .out_err(out_err12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the beats of one word applying the index rules directly.
  function automatic void model(input int w, input beat_t b[$],
                                output logic [15:0] d, output int c, output bit e);
    bit first = 1'b1;
    int prev = 0;
    d = '0;
    c = 0;
    e = 1'b0;
    foreach (b[i]) begin
      if (b[i].nul) continue;
      if (b[i].idx >= w || (!first && b[i].idx >= prev)) begin
        e = 1'b1;
      end else begin
        d[b[i].idx] = 1'b1;
        c++;
        prev = b[i].idx;
        first = 1'b0;
      end
    end
  endfunction

  task automatic add(input int idx);
    beat_t b;
    b.idx = idx;
    b.nul = 1'b0;
    cur.push_back(b);
  endtask

  task automatic add_null();
    beat_t b;
    b.idx = $urandom_range(0, 15);
    b.nul = 1'b1;
    cur.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input int idx, input bit nul, input bit last);
    int waited = 0;
    in_valid = 1'b1;
    in_index = 4'(idx);
    in_null  = nul;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("beat_timeout", 32'(in_ready), 32'd1);
    check("ready_match_12", 32'(in_ready12), 32'(in_ready));
    last_wait = waited;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_index = 4'($urandom_range(0, 15));
    in_null  = $urandom_range(0, 1);
    in_last  = $urandom_range(0, 1);
  endtask

  task automatic send_word(input bit gaps);
    exp_t e;
    model(16, cur, e.d16, e.c16, e.e16);
    model(12, cur, e.d12, e.c12, e.e12);
    exp_q.push_back(e);
    foreach (cur[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(cur[i].idx, cur[i].nul, i == cur.size() - 1);
    end
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_valid_12", 32'(out_valid12), 32'd1);
    cur.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Consumer: randomly throttles out_ready unless the main flow pins it.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = force_en ? force_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: scoreboards consumed words and checks that held words stay stable.
  initial begin
    bit          hv = 1'b0, hr = 1'b0;
    logic [15:0] hd = '0;
    logic [4:0]  hc = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hv = 1'b0;
      end else begin
        if (hv && !hr) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(hd));
          check("hold_count", 32'(out_count), 32'(hc));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("data16", 32'(out_data), 32'(e.d16));
            check("count16", 32'(out_count), 32'(e.c16));
            check("err16", 32'(out_err), 32'(e.e16));
            check("valid12", 32'(out_valid12), 32'd1);
            check("data12", 32'(out_data12), 32'(e.d12[11:0]));
            check("count12", 32'(out_count12), 32'(e.c12));
            check("err12", 32'(out_err12), 32'(e.e12));
          end
        end
        hv = out_valid;
        hr = out_ready;
        hd = out_data;
        hc = out_count;
      end
    end
  end

  initial begin
    int hi;
    rst = 1'b1;
    in_valid = 1'b0;
    in_index = '0;
    in_null = 1'b0;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reference patterns with an always-ready consumer.
    add(12); add(10); add(9); add(7); add(6); add(4); add(3); add(2); add(1);
    send_word(1'b0);
    add_null();
    send_word(1'b0);
    add(15);
    send_word(1'b0);

    // Back-pressure, then consume and accept in the same cycle.
    force_val = 1'b0;
    @(posedge clk);
    #1;
    add(14); add(12); add(10);
    send_word(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_data", 32'(out_data), 32'h5400);
      check("bp_count", 32'(out_count), 32'd3);
      if (i == 2) force_val = 1'b1;
      @(posedge clk);
      #1;
    end
    add(7); add(2);
    send_beat(cur[0].idx, 1'b0, 1'b0);
    check("no_bubble", 32'(last_wait), 32'd0);
    cur.pop_front();
    begin
      exp_t e;
      beat_t full[$];
      full.push_back('{idx: 7, nul: 1'b0});
      full.push_back('{idx: 2, nul: 1'b0});
      model(16, full, e.d16, e.c16, e.e16);
      model(12, full, e.d12, e.c12, e.e12);
      exp_q.push_back(e);
    end
    send_beat(2, 1'b0, 1'b1);
    cur.delete();

    // Ordering errors, error cleared per word, range errors on the narrow instance.
    add(5); add(5); add(9);
    send_word(1'b0);
    add(3);
    send_word(1'b0);
    add(13); add(4);
    send_word(1'b0);
    drain();

    // Asynchronous reset in the middle of a word.
    send_beat(11, 1'b0, 1'b0);
    send_beat(8, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_count", 32'(out_count), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    add(2);
    send_word(1'b0);
    drain();

    // Randomized words under random back-pressure.
    force_en = 1'b0;
    for (int w = 0; w < 60; w++) begin
      hi = 16;
      for (int n = $urandom_range(1, 6); n > 0; n--) begin
        case ($urandom_range(0, 7))
          0: add_null();
          1: add($urandom_range(0, 15));
          default: begin
            if (hi > 0) begin
              hi = $urandom_range(0, hi - 1);
              add(hi);
            end else begin
              add(0);
            end
          end
        endcase
      end
      send_word(1'b1);
    end
    force_en = 1'b1;
    force_val = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
